// File: rtl/tdc_pkg.sv
// tdc_pkg: shared FSM state type, settle length and code-width helper for the TDC sampler
package tdc_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, HOLD} state_t;
    localparam int SETTLE_CYCLES = 3;
    function automatic int code_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/tdc_therm2bin.sv
// tdc_therm2bin: polarity-corrected popcount of a captured tap vector, tolerant of bubbles
module tdc_therm2bin import tdc_pkg::*; #(
    parameter int N_TAPS = 16,
    parameter int CODE_W = code_width(N_TAPS)
) (
    input  logic              pol,
    input  logic [N_TAPS-1:0] taps,
    output logic [CODE_W-1:0] count
);
    logic [N_TAPS-1:0] corr;
    always_comb begin
        corr = pol ? taps : ~taps;
        count = '0;
        for (int i = 0; i < N_TAPS; i++) count = count + CODE_W'(corr[i]);
    end
endmodule

// File: rtl/tdc_avg_sampler.sv
// tdc_avg_sampler: launches edges into a tapped delay line and reports windowed avg/min/max/sat
module tdc_avg_sampler import tdc_pkg::*; #(
    parameter int N_TAPS  = 16,
    parameter int LOG_AVG = 2,
    parameter int CODE_W  = code_width(N_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              mode_cont,
    output logic              launch,
    input  logic [N_TAPS-1:0] taps,
    output logic              busy,
    output logic [CODE_W-1:0] res_avg,
    output logic [CODE_W-1:0] res_min,
    output logic [CODE_W-1:0] res_max,
    output logic              res_sat,
    output logic              res_valid,
    input  logic              res_ready
);
    localparam int AW = CODE_W + LOG_AVG;
    localparam int CW = LOG_AVG + 2;
    localparam int NS = 1 << LOG_AVG;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic mode_q, s1_pol, s2_pol, sat, sat_n, first, last, settled, acc_en;
    logic [N_TAPS-1:0] s1_taps, s2_taps;
    logic [CODE_W-1:0] count_c, s3_count, mn, mx, mn_n, mx_n;
    logic [AW-1:0] acc, acc_n;
    tdc_therm2bin #(.N_TAPS(N_TAPS), .CODE_W(CODE_W)) u_t2b (
        .pol(s2_pol),
        .taps(s2_taps),
        .count(count_c)
    );
    assign busy = state != IDLE;
    assign res_valid = state == HOLD;
    assign acc_en = en && state == ACCUM;
    always_comb begin
        first = cnt == '0;
        last = cnt == CW'(NS - 1);
        settled = cnt == CW'(SETTLE_CYCLES - 1);
        acc_n = first ? AW'(s3_count) : acc + AW'(s3_count);
        mn_n = (first || s3_count < mn) ? s3_count : mn;
        mx_n = (first || s3_count > mx) ? s3_count : mx;
        sat_n = (!first && sat) || s3_count == CODE_W'(N_TAPS);
        state_n = state;
        cnt_n = '0;
        case (state)
            IDLE:    state_n = (en && start) ? SETTLE : IDLE;
            SETTLE: begin
                state_n = settled ? ACCUM : SETTLE;
                cnt_n = settled ? '0 : cnt + CW'(1);
            end
            ACCUM: begin
                state_n = last ? HOLD : ACCUM;
                cnt_n = last ? '0 : cnt + CW'(1);
            end
            HOLD:    state_n = res_ready ? (mode_q ? SETTLE : IDLE) : HOLD;
            default: state_n = IDLE;
        endcase
        if (!en) state_n = IDLE;
        if (!en) cnt_n = '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            mode_q <= 1'b0;
            launch <= 1'b0;
            {s1_taps, s2_taps, s1_pol, s2_pol, s3_count} <= '0;
            {acc, mn, mx, sat} <= '0;
            {res_avg, res_min, res_max, res_sat} <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            s1_taps <= taps;
            s1_pol <= launch;
            s2_taps <= s1_taps;
            s2_pol <= s1_pol;
            s3_count <= count_c;
            if (state == IDLE && en && start) mode_q <= mode_cont;
            if (en && (state == SETTLE || state == ACCUM)) launch <= ~launch;
            acc <= acc_en ? acc_n : '0;
            if (acc_en) {mn, mx, sat} <= {mn_n, mx_n, sat_n};
            if (acc_en && last) begin
                res_avg <= CODE_W'(acc_n >> LOG_AVG);
                res_min <= mn_n;
                res_max <= mx_n;
                res_sat <= sat_n;
            end
        end
    end
endmodule

// File: tb/tb_tdc_avg_sampler.sv
// tb_tdc_avg_sampler: randomized windows against a popcount/average reference model
module tb_tdc_avg_sampler;
    localparam int N = 16;
    localparam int L = 2;
    localparam int W = 5;
    localparam int NS = 4;
    typedef logic [NS-1:0][N-1:0] win_t;
    logic clk = 0, rst = 1, en = 0, start = 0, mode_cont = 0, res_ready = 1;
    logic launch, busy, res_valid, res_sat;
    logic [W-1:0] res_avg, res_min, res_max;
    logic [N-1:0] pat = '1;
    logic [N-1:0] taps;
    int compared = 0, mismatched = 0, toggles = 0, vcnt = 0;

    // the external delay line: a launch edge of either polarity propagates through k taps
    assign taps = launch ? pat : ~pat;
    always #5 clk = ~clk;
    always @(launch) toggles++;
    always @(negedge clk) if (res_valid === 1'b1) vcnt++;

    tdc_avg_sampler #(.N_TAPS(N), .LOG_AVG(L)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .mode_cont(mode_cont),
        .launch(launch), .taps(taps), .busy(busy), .res_avg(res_avg), .res_min(res_min),
        .res_max(res_max), .res_sat(res_sat), .res_valid(res_valid), .res_ready(res_ready)
    );

    function automatic logic [N-1:0] therm(input int k);
        return N'((32'd1 << k) - 1);
    endfunction

    function automatic logic [3*W:0] model(input win_t p);
        int s = 0, mn = N, mx = 0;
        bit sat = 0;
        for (int j = 0; j < NS; j++) begin
            int c = $countones(p[j]);
            s += c;
            mn = c < mn ? c : mn;
            mx = c > mx ? c : mx;
            sat |= c == N;
        end
        return {W'(s >> L), W'(mn), W'(mx), sat};
    endfunction

    function automatic win_t rand_win();
        win_t p;
        for (int j = 0; j < NS; j++)
            p[j] = $urandom_range(0, 1) ? therm($urandom_range(0, N)) : N'($urandom);
        return p;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed(input win_t p);
        for (int j = 0; j < NS; j++) begin
            pat = p[j];
            tick();
        end
        pat = '1;
    endtask

    task automatic launch_window(input win_t p, input bit mode);
        pat = '1;
        start = 1;
        mode_cont = mode;
        tick();
        start = 0;
        feed(p);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (res_valid === 1'b1) ok = 1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst = 1;
        en = 0;
        tick(3);
        compared++;
        if ({launch, busy, res_valid} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want 000", {launch, busy, res_valid});
        end
        compared++;
        if ({res_avg, res_min, res_max, res_sat} !== '0) begin
            mismatched++;
            $display("FAIL reset_res: got %h want 0", {res_avg, res_min, res_max, res_sat});
        end
        rst = 0;
        en = 1;
        tick();
    endtask

    task automatic test_const();
        win_t p = {therm(5), therm(5), therm(5), therm(5)};
        bit ok;
        toggles = 0;
        vcnt = 0;
        launch_window(p, 0);
        wait_valid(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL const_timeout: got no res_valid want res_valid");
        end
        compared++;
        if ({res_avg, res_min, res_max, res_sat} !== model(p)) begin
            mismatched++;
            $display("FAIL const_res: got %h want %h", {res_avg, res_min, res_max, res_sat}, model(p));
        end
        tick();
        compared++;
        if ({busy, res_valid} !== 2'b00) begin
            mismatched++;
            $display("FAIL const_idle: got %b want 00", {busy, res_valid});
        end
        tick(3);
        compared++;
        if (vcnt !== 1) begin
            mismatched++;
            $display("FAIL const_pulses: got %0d want 1", vcnt);
        end
        compared++;
        if (toggles !== 7) begin
            mismatched++;
            $display("FAIL const_toggles: got %0d want 7", toggles);
        end
    endtask

    task automatic test_window(input string name, input win_t p);
        bit ok;
        launch_window(p, 0);
        wait_valid(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s_timeout: got no res_valid want res_valid", name);
        end
        compared++;
        if ({res_avg, res_min, res_max, res_sat} !== model(p)) begin
            mismatched++;
            $display("FAIL %s_res: got %h want %h", name, {res_avg, res_min, res_max, res_sat}, model(p));
        end
        tick();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_busy: got %b want 0", name, busy);
        end
        tick(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) test_window("random", rand_win());
    endtask

    task automatic test_continuous();
        win_t pa = rand_win(), pb = rand_win();
        logic lq;
        bit ok;
        res_ready = 0;
        launch_window(pa, 1);
        wait_valid(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL cont_timeout1: got no res_valid want res_valid");
        end
        lq = launch;
        for (int i = 0; i < 10; i++) begin
            tick();
            compared++;
            if ({res_valid, launch, res_avg, res_min, res_max, res_sat} !== {1'b1, lq, model(pa)}) begin
                mismatched++;
                $display("FAIL cont_hold: got %h want %h", {res_valid, launch, res_avg, res_min, res_max, res_sat}, {1'b1, lq, model(pa)});
            end
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        compared++;
        if ({busy, res_valid} !== 2'b10) begin
            mismatched++;
            $display("FAIL cont_restart: got %b want 10", {busy, res_valid});
        end
        feed(pb);
        wait_valid(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL cont_timeout2: got no res_valid want res_valid");
        end
        compared++;
        if ({res_avg, res_min, res_max, res_sat} !== model(pb)) begin
            mismatched++;
            $display("FAIL cont_res2: got %h want %h", {res_avg, res_min, res_max, res_sat}, model(pb));
        end
        en = 0;
        tick();
        compared++;
        if ({busy, res_valid} !== 2'b00) begin
            mismatched++;
            $display("FAIL cont_stop: got %b want 00", {busy, res_valid});
        end
        en = 1;
        res_ready = 1;
        tick();
    endtask

    task automatic test_abort(input bit use_rst);
        win_t big = {therm(16), therm(16), therm(14), therm(15)};
        win_t p7 = {therm(7), therm(7), therm(7), therm(7)};
        logic [3*W:0] prev = {res_avg, res_min, res_max, res_sat};
        bit ok;
        vcnt = 0;
        launch_window(big, 0);
        tick();
        if (use_rst) rst = 1;
        else en = 0;
        tick();
        compared++;
        if ({busy, res_valid} !== 2'b00) begin
            mismatched++;
            $display("FAIL abort%0d_idle: got %b want 00", use_rst, {busy, res_valid});
        end
        compared++;
        if (use_rst ? ({launch, res_avg, res_min, res_max, res_sat} !== '0) : ({res_avg, res_min, res_max, res_sat} !== prev)) begin
            mismatched++;
            $display("FAIL abort%0d_res: got %h want %h", use_rst, {launch, res_avg, res_min, res_max, res_sat}, use_rst ? 17'h0 : {1'b0, prev});
        end
        rst = 0;
        en = 1;
        tick(2);
        launch_window(p7, 0);
        wait_valid(ok);
        compared++;
        if (!ok || {res_avg, res_min, res_max, res_sat} !== model(p7)) begin
            mismatched++;
            $display("FAIL abort%0d_next: got %h want %h", use_rst, {res_avg, res_min, res_max, res_sat}, model(p7));
        end
        tick(2);
        compared++;
        if (vcnt !== 1) begin
            mismatched++;
            $display("FAIL abort%0d_pulses: got %0d want 1", use_rst, vcnt);
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_window("seq", {therm(8), therm(6), therm(4), therm(3)});
        test_window("bubble", {therm(9), therm(2), therm(16), 16'h002F});
        test_window("zero", {therm(0), therm(1), therm(0), therm(16)});
        test_random();
        test_continuous();
        test_abort(0);
        test_abort(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
